rom_fuse_key_loader: RTL
========================

Name: rom_fuse_key_loader

Overview:
- Upstream stage of the ROM fuse unlock logic. Sole driver of that logic's 32-bit REG0 key input; consumes its LOCKED output.
- Host stages a candidate key over a simple valid/ready write port and commits it. The block presents the key on REG0 for exactly one cycle, then checks LOCKED.
- Counts failed attempts and enforces a timed lockout. REG0 is 32'h0 at all other times, so the unlock value never appears on REG0 except during a commit.

Parameters:
- MAX_ATTEMPTS, 3: consecutive failed commits that trigger lockout (min 1).
- LOCKOUT_CYCLES, 1024: lockout duration in CLK cycles (min 1).
- FAIL_W, 2: width of FAIL_CNT; must hold MAX_ATTEMPTS.

Ports:
- CLK  in  1  clock
- RESETN  in  1  asynchronous active-low reset
- WR_VALID  in  1  host write request
- WR_READY  out  1  block can accept a write
- WR_ADDR  in  2  0 = key staging, 1 = command, 2/3 = reserved
- WR_DATA  in  32  write data
- REG0  out  32  key to fuse logic, registered
- LOCKED_IN  in  1  LOCKED from fuse logic
- BUSY  out  1  commit or lockout in progress
- UNLOCKED  out  1  fuse logic confirmed locked-in
- LOCKOUT  out  1  lockout timer running
- FAIL_CNT  out  FAIL_W  consecutive failed attempts

Behaviour:
- Reset (async assert, sync release): state IDLE, staged key 0, REG0 0, WR_READY 0 during reset, BUSY 0, UNLOCKED 0, LOCKOUT 0, FAIL_CNT 0, lockout counter 0.
- A write transfers on a CLK edge where WR_VALID && WR_READY. WR_READY=1 only in IDLE and DONE.
- Writes in DONE are accepted and dropped. Addr 2/3 writes are accepted and ignored.
- Addr 0: staged key <= WR_DATA. REG0 is unaffected.
- Addr 1 with WR_DATA[0]=1: commit. Addr 1 with WR_DATA[0]=0: no-op.
- States: IDLE, PRESENT, SETTLE, CHECK, LOCKOUT, DONE.
- IDLE:
  - Commit accepted at edge E0: -> PRESENT, and REG0 <= staged key at the same edge.
  - If LOCKED_IN=1 with no commit: -> DONE.
- PRESENT (1 cycle): REG0 = key. At the next edge -> SETTLE, REG0 <= 0.
- SETTLE (1 cycle): REG0 = 0. Covers the fuse logic's 2-edge latency. -> CHECK.
- CHECK (1 cycle): sample LOCKED_IN.
  - 1 -> DONE, UNLOCKED<=1, FAIL_CNT<=0.
  - 0 and FAIL_CNT+1 < MAX_ATTEMPTS -> IDLE, FAIL_CNT<=FAIL_CNT+1.
  - 0 and FAIL_CNT+1 == MAX_ATTEMPTS -> LOCKOUT, FAIL_CNT<=MAX_ATTEMPTS, counter<=LOCKOUT_CYCLES-1, LOCKOUT<=1.
- LOCKOUT: counter decrements each cycle. At 0 -> IDLE, LOCKOUT<=0, FAIL_CNT<=0. Total LOCKOUT high = LOCKOUT_CYCLES cycles.
- DONE: terminal until reset. UNLOCKED=1, REG0=0.
- BUSY=1 in PRESENT, SETTLE, CHECK, LOCKOUT.
- Commit-to-result: commit edge E0, result visible after edge E0+3.
- Commit and LOCKED_IN=1 in the same IDLE cycle: commit wins; the CHECK outcome decides.
- Reset mid-commit: REG0 returns to 0 immediately; the attempt is not counted.
- FAIL_CNT never exceeds MAX_ATTEMPTS and never wraps.

Optional Feature:
- Macro: ROM_FUSE_KEY_ZEROIZE_EN.
- Defined: staged key is cleared to 0 at the PRESENT->SETTLE edge. A repeat commit without a rewrite presents 32'h0.
- Undefined: staged key is retained until overwritten or reset.

Test Plan:
- Reset, write addr0=32'hDEADDEAD, addr1=1, with fuse model attached -> REG0=DEADDEAD for exactly 1 cycle after commit, 0 otherwise; UNLOCKED=1 and BUSY=0 after commit edge +3; FAIL_CNT=0; further writes have no effect.
- Key 32'h12345678 committed 3 times (MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16) -> FAIL_CNT 1, 2, then LOCKOUT=1 for exactly 16 cycles with WR_READY=0; then FAIL_CNT=0, IDLE.
- During lockout, hold WR_VALID with addr1=1 -> no transfer, REG0 stays 0; the commit is accepted on the first IDLE cycle.
- Two wrong commits, then correct key DEADDEAD -> UNLOCKED=1, FAIL_CNT cleared to 0.
- Assert RESETN low in the PRESENT cycle -> REG0=0 asynchronously, all status outputs 0, fuse stays unlocked-free.
- With ROM_FUSE_KEY_ZEROIZE_EN: write DEADDEAD, commit with LOCKED_IN forced 0, recommit -> second REG0 presentation is 32'h0. Without the macro -> DEADDEAD again.

Source files
------------

// File: rtl/rom_fuse_key_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rom_fuse_key_loader                                        |
// | Description : Stages a host key and presents it to the ROM fuse unlock   |
// |               logic on REG0 for exactly one cycle per commit. It then    |
// |               checks LOCKED_IN, counts consecutive failed attempts and   |
// |               enforces a timed lockout. REG0 is 32'h0 at all other times.|
// | Option      : ROM_FUSE_KEY_ZEROIZE_EN - when defined, the staged key is  |
// |               cleared once it has been presented.                        |
// | Ports       : CLK, RESETN (async assert, active low)                     |
// |               WR_VALID/WR_READY/WR_ADDR/WR_DATA - host write port        |
// |                 addr 0 = key staging, 1 = command (bit0 = commit)        |
// |               REG0      - key to fuse logic (registered)                 |
// |               LOCKED_IN - LOCKED from fuse logic                         |
// |               BUSY, UNLOCKED, LOCKOUT, FAIL_CNT - status                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rom_fuse_key_loader #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int FAIL_W         = 2
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [1:0]        WR_ADDR,
    input  logic [31:0]       WR_DATA,
    output logic [31:0]       REG0,
    input  logic              LOCKED_IN,
    output logic              BUSY,
    output logic              UNLOCKED,
    output logic              LOCKOUT,
    output logic [FAIL_W-1:0] FAIL_CNT
);

    localparam int                c_lock_w    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_lock_w-1:0] c_lock_load = c_lock_w'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W:0]   c_max_ext   = (FAIL_W+1)'(MAX_ATTEMPTS);
    localparam logic [FAIL_W-1:0] c_max_cnt   = FAIL_W'(MAX_ATTEMPTS);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_present = 3'd1;
    localparam logic [2:0] c_st_settle  = 3'd2;
    localparam logic [2:0] c_st_check   = 3'd3;
    localparam logic [2:0] c_st_lockout = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    logic [2:0]          r_state;
    logic [31:0]         r_key;
    logic [31:0]         r_reg0;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic [c_lock_w-1:0] r_lock_cnt;

    logic                w_idle;
    logic                w_done;
    logic                w_fire;
    logic                w_stage_wr;
    logic                w_commit;
    logic [FAIL_W:0]     w_fail_next;
    logic                w_last_try;

    assign w_idle      = (r_state == c_st_idle);
    assign w_done      = (r_state == c_st_done);
    // Ready is gated by RESETN so the host sees no acceptance while reset is held.
    assign WR_READY    = RESETN & (w_idle | w_done);
    assign w_fire      = WR_VALID & WR_READY;
    // Writes in DONE handshake normally but must not touch anything.
    assign w_stage_wr  = w_fire & w_idle & (WR_ADDR == 2'd0);
    assign w_commit    = w_fire & w_idle & (WR_ADDR == 2'd1) & WR_DATA[0];
    // One bit wider than FAIL_CNT so the increment can never wrap.
    assign w_fail_next = {1'b0, r_fail_cnt} + (FAIL_W+1)'(1);
    assign w_last_try  = (w_fail_next >= c_max_ext);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= c_st_idle;
            r_key      <= '0;
            r_reg0     <= '0;
            r_fail_cnt <= '0;
            r_lock_cnt <= '0;
        end else begin
            if (w_stage_wr) begin
                r_key <= WR_DATA;
            end
            case (r_state)
                c_st_idle: begin
                    // A commit takes priority over an already-asserted LOCKED_IN;
                    // the CHECK outcome then decides.
                    if (w_commit) begin
                        r_state <= c_st_present;
                        r_reg0  <= r_key;
                    end else if (LOCKED_IN) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_present: begin
                    r_state <= c_st_settle;
                    r_reg0  <= '0;
`ifdef ROM_FUSE_KEY_ZEROIZE_EN
                    r_key   <= '0;
`endif
                end
                // Spare cycle so the fuse logic's two-edge LOCKED latency has elapsed.
                c_st_settle: begin
                    r_state <= c_st_check;
                end
                c_st_check: begin
                    if (LOCKED_IN) begin
                        r_state    <= c_st_done;
                        r_fail_cnt <= '0;
                    end else if (w_last_try) begin
                        r_state    <= c_st_lockout;
                        r_fail_cnt <= c_max_cnt;
                        r_lock_cnt <= c_lock_load;
                    end else begin
                        r_state    <= c_st_idle;
                        r_fail_cnt <= w_fail_next[FAIL_W-1:0];
                    end
                end
                c_st_lockout: begin
                    if (r_lock_cnt == '0) begin
                        r_state    <= c_st_idle;
                        r_fail_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - c_lock_w'(1);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_done;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_reg0  <= '0;
                end
            endcase
        end
    end

    assign REG0     = r_reg0;
    assign BUSY     = (r_state == c_st_present) | (r_state == c_st_settle) |
                      (r_state == c_st_check)   | (r_state == c_st_lockout);
    assign UNLOCKED = w_done;
    assign LOCKOUT  = (r_state == c_st_lockout);
    assign FAIL_CNT = r_fail_cnt;

endmodule
`default_nettype wire
